// File: rtl/dl_sdram_sched.sv
// Arbitrates SDRAM between the data_io ROM download and the CPU ROM port:
// packs download bytes into masked 16-bit writes and sequences rom_loaded/core_reset.
module dl_sdram_sched #(
    parameter int unsigned    AW         = 22,
    parameter int unsigned    FIFO_DEPTH = 4,
    parameter logic [AW-1:0]  PARK_ADDR  = 'h1ffff,
    parameter int unsigned    RST_HOLD   = 16
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [24:0]   ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          ext_reset,
    output logic          ram_req,
    input  logic          ram_ack,
    output logic [AW-1:0] ram_addr,
    output logic [15:0]   ram_din,
    output logic [1:0]    ram_ds,
    output logic          ram_we,
    input  logic          cpu_rd,
    input  logic [AW-1:0] cpu_addr,
    output logic          rom_oe,
    output logic [AW-1:0] rom_addr,
    output logic          rom_loaded,
    output logic          core_reset,
    output logic          overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned HW = $clog2(RST_HOLD + 2);

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    ds;
        logic [15:0]   din;
    } wr_t;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t        state_q, state_d;
    wr_t           pend_q, pend_d, out_q, out_d, push_data;
    logic          pv_q, pv_d;
    wr_t           fifo_q [FIFO_DEPTH];
    logic [PW:0]   wp_q, rp_q;
    logic          push, pop, full, empty, ovf_set;
    logic          req_q, req_d;
    logic          ovf_q, dl_q, seen_q, seen_d, loaded_q, loaded_d;
    logic          we_q, oe_q, core_q, core_d, busy;
    logic [AW-1:0] raddr_q;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] waddr;
    logic          unused_addr;

    assign waddr       = ioctl_addr[AW:1];
    assign unused_addr = ^ioctl_addr[24:AW+1];
    assign empty       = (wp_q == rp_q);
    assign full        = (wp_q[PW] != rp_q[PW]) && (wp_q[PW-1:0] == rp_q[PW-1:0]);
    assign busy        = ioctl_download | pv_q | ~empty | (state_q == S_WAIT);

    // A pending entry that cannot be pushed stays put; the flush after the
    // download window retries every cycle until the FIFO has room.
    always_comb begin
        pv_d      = pv_q;
        pend_d    = pend_q;
        push      = 1'b0;
        push_data = pend_q;
        ovf_set   = 1'b0;
        if (ioctl_wr) begin
            if (ioctl_addr[0] && pv_q && pend_q.addr == waddr && pend_q.ds == 2'b01) begin
                if (full) begin
                    ovf_set = 1'b1;
                end else begin
                    push      = 1'b1;
                    push_data = {pend_q.addr, 2'b11, ioctl_dout, pend_q.din[7:0]};
                    pv_d      = 1'b0;
                end
            end else if (pv_q && full) begin
                ovf_set = 1'b1;
            end else begin
                push   = pv_q;
                pv_d   = 1'b1;
                pend_d = {waddr, (ioctl_addr[0] ? 2'b10 : 2'b01), ioctl_dout, ioctl_dout};
            end
        end else if (!ioctl_download && pv_q && !full) begin
            push = 1'b1;
            pv_d = 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        out_d   = out_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: if (!empty) begin
                pop     = 1'b1;
                out_d   = fifo_q[rp_q[PW-1:0]];
                req_d   = ~req_q;
                state_d = S_WAIT;
            end
            S_WAIT: if (ram_ack == req_q) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // hold_d feeds core_d directly so core_reset drops exactly RST_HOLD cycles after rom_loaded.
    always_comb begin
        seen_d   = seen_q | ioctl_download;
        loaded_d = loaded_q;
        hold_d   = (hold_q != '0) ? hold_q - 1'b1 : hold_q;
        if (ioctl_download && !dl_q) begin
            loaded_d = 1'b0;
            hold_d   = '0;
        end else if (seen_q && !busy) begin
            loaded_d = 1'b1;
            seen_d   = 1'b0;
            hold_d   = HW'(RST_HOLD);
        end
        core_d = ext_reset | ~loaded_d | (hold_d != '0);
    end

    always_ff @(posedge clk_sys) begin
        if (push) fifo_q[wp_q[PW-1:0]] <= push_data;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            pend_q   <= '0;
            pv_q     <= 1'b0;
            out_q    <= '0;
            wp_q     <= '0;
            rp_q     <= '0;
            req_q    <= 1'b0;
            ovf_q    <= 1'b0;
            dl_q     <= 1'b0;
            seen_q   <= 1'b0;
            loaded_q <= 1'b0;
            hold_q   <= '0;
            we_q     <= 1'b0;
            oe_q     <= 1'b0;
            raddr_q  <= PARK_ADDR;
            core_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            pv_q     <= pv_d;
            out_q    <= out_d;
            if (push) wp_q <= wp_q + 1'b1;
            if (pop)  rp_q <= rp_q + 1'b1;
            req_q    <= req_d;
            ovf_q    <= ovf_q | ovf_set;
            dl_q     <= ioctl_download;
            seen_q   <= seen_d;
            loaded_q <= loaded_d;
            hold_q   <= hold_d;
            we_q     <= busy;
            oe_q     <= cpu_rd & ~busy;
            raddr_q  <= busy ? PARK_ADDR : cpu_addr;
            core_q   <= core_d;
        end
    end

    assign ram_req    = req_q;
    assign ram_addr   = out_q.addr;
    assign ram_din    = out_q.din;
    assign ram_ds     = out_q.ds;
    assign ram_we     = we_q;
    assign rom_oe     = oe_q;
    assign rom_addr   = raddr_q;
    assign rom_loaded = loaded_q;
    assign core_reset = core_q;
    assign overflow   = ovf_q;

endmodule
